// File: rtl/garage_door_sequencer_pkg.sv
// Shared definitions for the garage door sequencer: state encoding, default timing
// and a helper that identifies the counted states.
package garage_door_sequencer_pkg;

  localparam int DEAD_TIME_DEF  = 4;
  localparam int MAX_TRAVEL_DEF = 120;
  localparam int CNT_W_DEF      = 8;

  typedef enum logic [2:0] {
    ST_OPEN     = 3'd0,
    ST_CLOSED   = 3'd1,
    ST_OPENING  = 3'd2,
    ST_CLOSING  = 3'd3,
    ST_STOPPED  = 3'd4,
    ST_PAUSE    = 3'd5,
    ST_FAULT    = 3'd6
  } state_e;

  // States whose dwell time is tracked by the shared counter.
  function automatic logic is_timed(input state_e s);
    return (s == ST_OPENING) || (s == ST_CLOSING) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/garage_door_sequencer_rise_detect.sv
// Rising-edge detector for a level button: a held button yields a single-cycle pulse.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = level;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/garage_door_sequencer.sv
// Garage door command sequencer: arbitrates wall/remote commands, enforces motor
// dead-time on reversal, and handles obstacle, travel timeout and limit faults.
module garage_door_sequencer
  import garage_door_sequencer_pkg::*;
#(
  parameter int DEAD_TIME  = DEAD_TIME_DEF,
  parameter int MAX_TRAVEL = MAX_TRAVEL_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wall_open,
  input  logic       wall_close,
  input  logic       remote,
  input  logic       obstacle,
  input  logic       door_up,
  input  logic       door_down,
  input  logic       fault_clear,
  output logic       power_up,
  output logic       power_down,
  output logic       fault,
  output logic [2:0] state_out
);

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(MAX_TRAVEL - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST  = CNT_W'(DEAD_TIME - 1);

  logic wall_open_rise;
  logic wall_close_rise;
  logic remote_rise;

  rise_detect u_wall_open (
    .clock (clock),
    .reset (reset),
    .level (wall_open),
    .rise  (wall_open_rise)
  );

  rise_detect u_wall_close (
    .clock (clock),
    .reset (reset),
    .level (wall_close),
    .rise  (wall_close_rise)
  );

  rise_detect u_remote (
    .clock (clock),
    .reset (reset),
    .level (remote),
    .rise  (remote_rise)
  );

  state_e           state_q,      state_d;
  logic             last_dir_q,   last_dir_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             power_up_q,   power_up_d;
  logic             power_down_q, power_down_d;
  logic             fault_q,      fault_d;

  logic limit_fault;
  logic travel_timeout;
  logic pause_done;

  assign limit_fault    = door_up & door_down;
  assign travel_timeout = ((state_q == ST_OPENING) || (state_q == ST_CLOSING)) &&
                          (cnt_q == TRAVEL_LAST);
  assign pause_done     = (cnt_q == PAUSE_LAST);

  // Commands that would have no effect in a state fall through to lower priorities.
  always_comb begin
    // NOTE: a default before any branch keeps always_comb free of inferred latches.
    state_d = state_q;
    if (state_q == ST_FAULT) begin
      if (fault_clear) state_d = ST_STOPPED;
    end else if (limit_fault || travel_timeout) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_OPEN: begin
          if ((wall_close_rise || remote_rise) && !obstacle) state_d = ST_CLOSING;
        end
        ST_CLOSED: begin
          if (wall_open_rise || remote_rise) state_d = ST_OPENING;
        end
        ST_OPENING: begin
          if (wall_close_rise)  state_d = ST_PAUSE;
          else if (remote_rise) state_d = ST_STOPPED;
          else if (door_up)     state_d = ST_OPEN;
        end
        ST_CLOSING: begin
          if (obstacle || wall_open_rise) state_d = ST_PAUSE;
          else if (remote_rise)           state_d = ST_STOPPED;
          else if (door_down)             state_d = ST_CLOSED;
        end
        ST_STOPPED: begin
          if (wall_open_rise)                     state_d = ST_OPENING;
          else if (wall_close_rise && !obstacle)  state_d = ST_CLOSING;
          else if (remote_rise)                   state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          // The pause target is always the reverse of the last motion.
          if (pause_done) state_d = last_dir_q ? ST_CLOSING : ST_OPENING;
        end
        default: state_d = ST_FAULT;
      endcase
    end
  end

  always_comb begin
    last_dir_d = last_dir_q;
    if ((state_d == ST_OPENING) && (state_q != ST_OPENING)) last_dir_d = 1'b1;
    if ((state_d == ST_CLOSING) && (state_q != ST_CLOSING)) last_dir_d = 1'b0;
    cnt_d = (is_timed(state_d) && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;
  end

  // Outputs decode the next state so the drive registers change on the same edge.
  always_comb begin
    power_up_d   = (state_d == ST_OPENING);
    power_down_d = (state_d == ST_CLOSING);
    fault_d      = (state_d == ST_FAULT);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_STOPPED;
      last_dir_q   <= 1'b1;
      cnt_q        <= '0;
      power_up_q   <= 1'b0;
      power_down_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_dir_q   <= last_dir_d;
      cnt_q        <= cnt_d;
      power_up_q   <= power_up_d;
      power_down_q <= power_down_d;
      fault_q      <= fault_d;
    end
  end

  assign power_up   = power_up_q;
  assign power_down = power_down_q;
  assign fault      = fault_q;
  assign state_out  = state_q;

endmodule
